// File: rtl/even_result_pipe.sv
// Result staging for the even execution pipe: carries each result through s2..s7,
// exposes per-stage forwarding taps and performs the register-file write from s7.
module even_result_pipe #(
  parameter int unsigned REG_ADDR_WD = 7,
  parameter int unsigned REG_DATA_WD = 128,
  parameter int unsigned LAT_WD      = 3,
  parameter int unsigned CNT_WD      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  input  logic [REG_ADDR_WD-1:0] in_RT_addr,
  input  logic [REG_DATA_WD-1:0] in_RT,
  input  logic [LAT_WD-1:0]      in_lat,
  input  logic                   flush,
  output logic [REG_ADDR_WD-1:0] rf_addr_s2_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s3_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s4_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s5_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s6_ep,
  output logic [REG_ADDR_WD-1:0] rf_addr_s7_ep,
  output logic [REG_DATA_WD-1:0] rf_data_s2_ep,
  output logic [REG_DATA_WD-1:0] rf_data_s3_ep,
  output logic [REG_DATA_WD-1:0] rf_data_s4_ep,
  output logic [REG_DATA_WD-1:0] rf_data_s5_ep,
  output logic [REG_DATA_WD-1:0] rf_data_s6_ep,
  output logic [REG_DATA_WD-1:0] rf_data_s7_ep,
  output logic [5:0]             fwd_vld,
  output logic                   wb_en,
  output logic [REG_ADDR_WD-1:0] wb_addr,
  output logic [REG_DATA_WD-1:0] wb_data,
  output logic [CNT_WD-1:0]      wb_count
);

  localparam int unsigned NSTG = 6;

  // Index 0 is stage s2, index NSTG-1 is stage s7.
  logic                   stg_vld  [NSTG];
  logic [REG_ADDR_WD-1:0] stg_addr [NSTG];
  logic [REG_DATA_WD-1:0] stg_data [NSTG];
  logic [LAT_WD-1:0]      stg_lat  [NSTG];

  logic                   cap_vld;
  logic [31:0]            lat_ext;
  logic [LAT_WD-1:0]      lat_sat;
  logic [NSTG-1:0]        rdy;
  logic [REG_ADDR_WD-1:0] tap_addr [NSTG];
  logic [REG_DATA_WD-1:0] tap_data [NSTG];

  assign cap_vld = in_vld & ~flush;

  // Clamp the requested forwarding stage into the 2..7 window the pipe actually has.
  always_comb begin
    lat_ext = 32'(in_lat);
    lat_sat = in_lat;
    if (lat_ext < 32'd2) begin
      lat_sat = LAT_WD'(2);
    end else if (lat_ext > 32'd7) begin
      lat_sat = LAT_WD'(7);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTG; k++) begin
        stg_vld[k]  <= 1'b0;
        stg_addr[k] <= '0;
        stg_data[k] <= '0;
        stg_lat[k]  <= '0;
      end
      wb_count <= '0;
    end else begin
      stg_vld[0]  <= cap_vld;
      stg_addr[0] <= cap_vld ? in_RT_addr : '0;
      stg_data[0] <= cap_vld ? in_RT : '0;
      stg_lat[0]  <= cap_vld ? lat_sat : '0;
      for (int k = 1; k < NSTG; k++) begin
        stg_vld[k]  <= stg_vld[k-1] & ~flush;
        stg_addr[k] <= stg_addr[k-1];
        stg_data[k] <= stg_data[k-1];
        stg_lat[k]  <= stg_lat[k-1];
      end
      // The s7 entry retires on this edge regardless of flush.
      if (stg_vld[NSTG-1]) begin
        wb_count <= wb_count + CNT_WD'(1);
      end
    end
  end

  // A stage is forwardable once its stage number reaches the result's latency.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < NSTG; k++) begin
      rdy[k]      = stg_vld[k] && (32'(k + 2) >= 32'(stg_lat[k]));
      tap_addr[k] = stg_vld[k] ? stg_addr[k] : '0;
      tap_data[k] = rdy[k] ? stg_data[k] : '0;
    end
  end

  assign fwd_vld = rdy;

  assign rf_addr_s2_ep = tap_addr[0];
  assign rf_addr_s3_ep = tap_addr[1];
  assign rf_addr_s4_ep = tap_addr[2];
  assign rf_addr_s5_ep = tap_addr[3];
  assign rf_addr_s6_ep = tap_addr[4];
  assign rf_addr_s7_ep = tap_addr[5];
  assign rf_data_s2_ep = tap_data[0];
  assign rf_data_s3_ep = tap_data[1];
  assign rf_data_s4_ep = tap_data[2];
  assign rf_data_s5_ep = tap_data[3];
  assign rf_data_s6_ep = tap_data[4];
  assign rf_data_s7_ep = tap_data[5];

  assign wb_en   = stg_vld[NSTG-1];
  assign wb_addr = stg_addr[NSTG-1];
  assign wb_data = stg_data[NSTG-1];

endmodule

// File: tb/tb_even_result_pipe.sv
// Bench for even_result_pipe: directed scenarios plus a random stream checked against
// an age-ordered queue model; a 3-bit-counter instance exercises counter wrap.
module tb_even_result_pipe;

  logic         clk = 1'b0;
  logic         rst, in_vld, flush;
  logic [6:0]   in_RT_addr;
  logic [127:0] in_RT;
  logic [2:0]   in_lat;

  logic [6:0]   a2, a3, a4, a5, a6, a7, wb_addr;
  logic [127:0] d2, d3, d4, d5, d6, d7, wb_data;
  logic [5:0]   fwd_vld;
  logic         wb_en;
  logic [31:0]  wb_count;

  logic [6:0]   wa2, wa3, wa4, wa5, wa6, wa7, w_wb_addr;
  logic [127:0] wd2, wd3, wd4, wd5, wd6, wd7, w_wb_data;
  logic [5:0]   w_fwd_vld;
  logic         w_wb_en;
  logic [2:0]   w_wb_count;

  logic [6:0]   ta [6];
  logic [127:0] td [6];
  logic [6:0]   wta [6];
  logic [127:0] wtd [6];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic         v;
    logic [6:0]   a;
    logic [127:0] d;
    logic [2:0]   lat;
  } ent_t;

  ent_t q[$];       // q[i] = result that entered i edges ago (stage s(i+2))
  int unsigned cnt;  // writebacks since reset

  even_result_pipe dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_RT_addr(in_RT_addr), .in_RT(in_RT),
    .in_lat(in_lat), .flush(flush),
    .rf_addr_s2_ep(a2), .rf_addr_s3_ep(a3), .rf_addr_s4_ep(a4),
    .rf_addr_s5_ep(a5), .rf_addr_s6_ep(a6), .rf_addr_s7_ep(a7),
    .rf_data_s2_ep(d2), .rf_data_s3_ep(d3), .rf_data_s4_ep(d4),
    .rf_data_s5_ep(d5), .rf_data_s6_ep(d6), .rf_data_s7_ep(d7),
    .fwd_vld(fwd_vld), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_count(wb_count)
  );

  even_result_pipe #(.CNT_WD(3)) dut_w (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_RT_addr(in_RT_addr), .in_RT(in_RT),
    .in_lat(in_lat), .flush(flush),
    .rf_addr_s2_ep(wa2), .rf_addr_s3_ep(wa3), .rf_addr_s4_ep(wa4),
    .rf_addr_s5_ep(wa5), .rf_addr_s6_ep(wa6), .rf_addr_s7_ep(wa7),
    .rf_data_s2_ep(wd2), .rf_data_s3_ep(wd3), .rf_data_s4_ep(wd4),
    .rf_data_s5_ep(wd5), .rf_data_s6_ep(wd6), .rf_data_s7_ep(wd7),
    .fwd_vld(w_fwd_vld), .wb_en(w_wb_en), .wb_addr(w_wb_addr), .wb_data(w_wb_data),
    .wb_count(w_wb_count)
  );

  assign ta[0] = a2; assign ta[1] = a3; assign ta[2] = a4;
  assign ta[3] = a5; assign ta[4] = a6; assign ta[5] = a7;
  assign td[0] = d2; assign td[1] = d3; assign td[2] = d4;
  assign td[3] = d5; assign td[4] = d6; assign td[5] = d7;
  assign wta[0] = wa2; assign wta[1] = wa3; assign wta[2] = wa4;
  assign wta[3] = wa5; assign wta[4] = wa6; assign wta[5] = wa7;
  assign wtd[0] = wd2; assign wtd[1] = wd3; assign wtd[2] = wd4;
  assign wtd[3] = wd5; assign wtd[4] = wd6; assign wtd[5] = wd7;

  always #5 clk = ~clk;

  function automatic logic [2:0] sat(input logic [2:0] l);
    return (l < 3'd2) ? 3'd2 : l;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock edge and apply the same edge to the reference model.
  task automatic tick();
    ent_t e;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 6; i++) q.push_back('0);
      cnt = 0;
    end else begin
      if (q[5].v) cnt++;
      void'(q.pop_back());
      if (flush) for (int i = 0; i < q.size(); i++) q[i].v = 1'b0;
      e = '0;
      if (in_vld && !flush) e = '{v: 1'b1, a: in_RT_addr, d: in_RT, lat: sat(in_lat)};
      q.push_front(e);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] a, input logic [127:0] d,
                       input logic [2:0] l);
    in_vld = v; in_RT_addr = a; in_RT = d; in_lat = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 7'h33, rnd128(), 3'd2);
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, 7'h0, 128'h0, 3'd0);
    checks++;
    if ({fwd_vld, wb_en, wb_addr, wb_data, wb_count} !== '0) begin
      failures++;
      $display("FAIL reset_outs fwd=%b en=%b addr=%h cnt=%0d exp all zero", fwd_vld, wb_en, wb_addr, wb_count);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({ta[k], td[k]} !== '0) begin
        failures++;
        $display("FAIL reset_tap s%0d got=%h/%h exp=0/0", k + 2, ta[k], td[k]);
      end
    end
  endtask

  task automatic test_single();
    logic [127:0] d = {32'h12345678, rnd128() & {32'h0, {96{1'b1}}}};
    int unsigned base = cnt;
    drive(1'b1, 7'h05, d, 3'd2);
    tick();
    drive(1'b0, 7'h0, 128'h0, 3'd0);
    for (int e = 0; e <= 5; e++) begin
      if (e > 0) tick();
      checks++;
      if (fwd_vld !== 6'(1 << e) || wb_en !== (e == 5)) begin
        failures++;
        $display("FAIL single_e%0d fwd=%b en=%b exp fwd=%b en=%b", e, fwd_vld, wb_en, 6'(1 << e), (e == 5));
      end
    end
    checks++;
    if (wb_addr !== 7'h05 || wb_data !== d) begin
      failures++;
      $display("FAIL single_wb got=%h/%h exp=05/%h", wb_addr, wb_data, d);
    end
    tick();
    checks++;
    if (wb_count !== base + 1 || wb_en !== 1'b0) begin
      failures++;
      $display("FAIL single_cnt got=%0d en=%b exp=%0d en=0", wb_count, wb_en, base + 1);
    end
  endtask

  task automatic test_latency4();
    logic [127:0] d = rnd128() | 128'h1;
    drive(1'b1, 7'h10, d, 3'd4);
    tick();
    drive(1'b0, 7'h0, 128'h0, 3'd0);
    for (int e = 0; e <= 2; e++) begin
      if (e > 0) tick();
      checks++;
      if (ta[e] !== 7'h10 || td[e] !== ((e == 2) ? d : 128'h0) ||
          fwd_vld !== ((e == 2) ? 6'b000100 : 6'b000000)) begin
        failures++;
        $display("FAIL lat4_e%0d addr=%h data=%h fwd=%b exp addr=10 ready=%0d", e, ta[e], td[e], fwd_vld, (e == 2));
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_saturation();
    logic [2:0] lats [2] = '{3'd0, 3'd7};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 7'(7'h20 + i), rnd128(), lats[i]);
      tick();
      drive(1'b0, 7'h0, 128'h0, 3'd0);
      for (int e = 0; e <= 5; e++) begin
        logic [5:0] exp_f;
        if (e > 0) tick();
        exp_f = (e + 2 >= int'(sat(lats[i]))) ? 6'(1 << e) : 6'b0;
        checks++;
        if (fwd_vld !== exp_f) begin
          failures++;
          $display("FAIL sat_lat%0d_e%0d fwd=%b exp=%b", lats[i], e, fwd_vld, exp_f);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int unsigned base = cnt;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 7'(i), rnd128(), 3'd2);
      tick();
    end
    drive(1'b0, 7'h0, 128'h0, 3'd0);
    checks++;
    if (fwd_vld !== 6'h3f) begin
      failures++;
      $display("FAIL b2b_fwd got=%b exp=111111", fwd_vld);
    end
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) tick();
      checks++;
      if (wb_en !== 1'b1 || wb_addr !== 7'(i)) begin
        failures++;
        $display("FAIL b2b_wb%0d en=%b addr=%h exp en=1 addr=%h", i, wb_en, wb_addr, 7'(i));
      end
    end
    tick();
    checks++;
    if (wb_count !== base + 6 || w_wb_count !== 3'(base + 6) || wb_en !== 1'b0) begin
      failures++;
      $display("FAIL b2b_cnt got=%0d/%0d en=%b exp=%0d/%0d", wb_count, w_wb_count, wb_en, base + 6, 3'(base + 6));
    end
  endtask

  task automatic test_flush();
    int unsigned base = cnt;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 7'(i), rnd128(), 3'd2);
      tick();
    end
    drive(1'b0, 7'h0, 128'h0, 3'd0);
    tick(); tick();
    checks++;
    if (wb_en !== 1'b1 || wb_addr !== 7'h01) begin
      failures++;
      $display("FAIL flush_pre en=%b addr=%h exp en=1 addr=01", wb_en, wb_addr);
    end
    flush = 1'b1;
    drive(1'b1, 7'h7f, rnd128(), 3'd2);
    tick();
    flush = 1'b0;
    drive(1'b0, 7'h0, 128'h0, 3'd0);
    checks++;
    if (wb_count !== base + 1 || fwd_vld !== 6'b0 || wb_en !== 1'b0) begin
      failures++;
      $display("FAIL flush_post cnt=%0d fwd=%b en=%b exp cnt=%0d fwd=0 en=0", wb_count, fwd_vld, wb_en, base + 1);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({ta[k], td[k]} !== '0) begin
        failures++;
        $display("FAIL flush_tap s%0d got=%h/%h exp=0/0", k + 2, ta[k], td[k]);
      end
    end
    for (int e = 0; e < 6; e++) begin
      tick();
      checks++;
      if (wb_en !== 1'b0 || wb_count !== base + 1) begin
        failures++;
        $display("FAIL flush_drain%0d en=%b cnt=%0d exp en=0 cnt=%0d", e, wb_en, wb_count, base + 1);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'(7'h40 + i), rnd128(), 3'(i));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 7'h0, 128'h0, 3'd0);
    checks++;
    if ({fwd_vld, wb_en, wb_addr, wb_data, wb_count, w_wb_count} !== '0) begin
      failures++;
      $display("FAIL rstmid_outs fwd=%b en=%b addr=%h cnt=%0d/%0d exp all zero", fwd_vld, wb_en, wb_addr, wb_count, w_wb_count);
    end
    for (int e = 0; e < 6; e++) begin
      tick();
      checks++;
      if (wb_en !== 1'b0 || fwd_vld !== 6'b0 || wb_count !== 32'd0) begin
        failures++;
        $display("FAIL rstmid_drain%0d en=%b fwd=%b cnt=%0d exp 0", e, wb_en, fwd_vld, wb_count);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [5:0] ef;
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 24) == 0);
      drive(($urandom_range(0, 3) != 0), 7'($urandom), rnd128(), 3'($urandom));
      tick();
      ef = '0;
      for (int k = 0; k < 6; k++) begin
        logic [6:0]   ea;
        logic [127:0] ed;
        ef[k] = q[k].v && (k + 2 >= int'(q[k].lat));
        ea = q[k].v ? q[k].a : 7'h0;
        ed = ef[k] ? q[k].d : 128'h0;
        checks++;
        if ({ta[k], td[k]} !== {ea, ed} || {wta[k], wtd[k]} !== {ea, ed}) begin
          failures++;
          $display("FAIL rnd_tap s%0d cyc=%0d got=%h/%h exp=%h/%h", k + 2, cyc, ta[k], td[k], ea, ed);
        end
      end
      checks++;
      if (fwd_vld !== ef || w_fwd_vld !== ef || wb_en !== q[5].v || w_wb_en !== q[5].v) begin
        failures++;
        $display("FAIL rnd_ctl cyc=%0d fwd=%b en=%b exp fwd=%b en=%b", cyc, fwd_vld, wb_en, ef, q[5].v);
      end
      if (q[5].v) begin
        checks++;
        if (wb_addr !== q[5].a || wb_data !== q[5].d || w_wb_addr !== q[5].a || w_wb_data !== q[5].d) begin
          failures++;
          $display("FAIL rnd_wb cyc=%0d got=%h/%h exp=%h/%h", cyc, wb_addr, wb_data, q[5].a, q[5].d);
        end
      end
      checks++;
      if (wb_count !== cnt || w_wb_count !== 3'(cnt)) begin
        failures++;
        $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, wb_count, w_wb_count, cnt, 3'(cnt));
      end
    end
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 7'h0, 128'h0, 3'd0);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) q.push_back('0);
    cnt = 0;
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 7'h0, 128'h0, 3'd0);
    test_reset();
    test_single();
    test_latency4();
    test_saturation();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
